// File: rtl/deadlock_confirm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deadlock_pkg
// Description : Shared types and helpers for the deadlock confirmation block.
// Revision    : 1.0 - initial release
// ============================================================================
package deadlock_pkg;

  // FSM state with a fixed 2-bit encoding that is exported on state_o.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CONFIRMED = 2'd2
  } dl_state_t;

  localparam int EVT_W       = 8;

  // Default process/axis geometry of the observed dataflow region.
  localparam int SNAP_PROC_W = 13;
  localparam int SNAP_AXIS_W = 3;

  // Captured process-state picture for the default geometry.
  typedef struct packed {
    logic [SNAP_PROC_W-1:0] idle;
    logic [SNAP_PROC_W-1:0] chan_block;
    logic [SNAP_AXIS_W-1:0] axis;
  } dl_snap_t;

  // Saturating increment for the confirmed-event counter.
  function automatic logic [EVT_W-1:0] evt_sat_inc(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + EVT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deadlock_confirm_stable_counter.sv
`default_nettype none
// ============================================================================
// Module      : dl_stable_counter
// Description : Holds the captured process-state picture and counts how many
//               consecutive samples it has stayed unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_stable_counter #(
  parameter int W      = 29,
  parameter int CNT_W  = 16,
  parameter int TARGET = 1000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] snap_o,
  output logic         stable_hit_o,
  output logic         changed_o
);

  logic [W-1:0]     snap_q, snap_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

  // Next-state: clear beats load beats increment; snapshot only moves on load.
  always_comb begin
    snap_d     = snap_q;
    stab_cnt_d = stab_cnt_q;
    if (clr_i) begin
      stab_cnt_d = '0;
    end else if (load_i) begin
      snap_d     = cur_i;
      stab_cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end
  end

  // Snapshot and stability counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      snap_q     <= snap_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign snap_o       = snap_q;
  assign changed_o    = (cur_i != snap_q);
  // The current sample is the TARGET-th stable one when the count reads TARGET-1.
  assign stable_hit_o = (stab_cnt_q == CNT_W'(TARGET - 1));

endmodule
`default_nettype wire

// File: rtl/deadlock_confirm.sv
`default_nettype none
// ============================================================================
// Module      : deadlock_confirm
// Description : Filters the deadlock monitor's per-cycle block indication and
//               declares a sticky deadlock once block has been held with a
//               frozen process-state picture for CONFIRM_CYCLES cycles.
//               Optional DEADLOCK_CONFIRM_REPORT_EN adds simulation reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module deadlock_confirm
  import deadlock_pkg::*;
#(
  parameter int NUM_PROC       = 13,
  parameter int NUM_AXIS       = 3,
  parameter int CONFIRM_CYCLES = 1000,
  parameter int CNT_W          = 16,
  parameter int CYC_W          = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_PROC-1:0] proc_idle_vec,
  input  logic [NUM_PROC-1:0] proc_chan_block_vec,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                deadlock,
  output logic                deadlock_pulse,
  output logic [NUM_PROC-1:0] snap_idle,
  output logic [NUM_PROC-1:0] snap_chan_block,
  output logic [NUM_AXIS-1:0] snap_axis,
  output logic [CYC_W-1:0]    detect_cycle,
  output logic [EVT_W-1:0]    event_count,
  output logic [1:0]          state_o
);

  localparam int VEC_W = 2 * NUM_PROC + NUM_AXIS;

  dl_state_t        state_q, state_d;
  logic             deadlock_q, deadlock_d;
  logic             pulse_q;
  logic [CYC_W-1:0] cycle_cnt_q;
  logic [CYC_W-1:0] detect_q;
  logic [EVT_W-1:0] evt_q;

  logic             w_load, w_inc, w_clr, w_confirm;
  logic             w_stable_hit, w_changed;
  logic [VEC_W-1:0] w_cur, w_snap;

  assign w_cur = {proc_idle_vec, proc_chan_block_vec, axis_block_sigs};

  dl_stable_counter #(
    .W      (VEC_W),
    .CNT_W  (CNT_W),
    .TARGET (CONFIRM_CYCLES)
  ) u_stable (
    .clock        (clock),
    .reset        (reset),
    .load_i       (w_load),
    .inc_i        (w_inc),
    .clr_i        (w_clr),
    .cur_i        (w_cur),
    .snap_o       (w_snap),
    .stable_hit_o (w_stable_hit),
    .changed_o    (w_changed)
  );

  // Next-state and counter control; clear always beats a new block sample.
  always_comb begin
    state_d    = state_q;
    deadlock_d = deadlock_q;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_clr      = 1'b0;
    w_confirm  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (block_in && !clear) begin
          w_load = 1'b1;
          if (CONFIRM_CYCLES == 1) begin
            state_d   = CONFIRMED;
            w_confirm = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (clear || !block_in) begin
          state_d = IDLE;
          w_clr   = 1'b1;
        end else if (w_changed) begin
          // A moving picture is progress: restart the count from this sample.
          w_load = 1'b1;
        end else if (w_stable_hit) begin
          state_d   = CONFIRMED;
          w_confirm = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      CONFIRMED: begin
        if (clear) begin
          state_d    = IDLE;
          deadlock_d = 1'b0;
          w_clr      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        w_clr   = 1'b1;
      end
    endcase
    if (w_confirm) deadlock_d = 1'b1;
  end

  // FSM, flags, timestamp, event counter and free-running cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      deadlock_q  <= 1'b0;
      pulse_q     <= 1'b0;
      cycle_cnt_q <= '0;
      detect_q    <= '0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      deadlock_q  <= deadlock_d;
      pulse_q     <= w_confirm;
      cycle_cnt_q <= (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CYC_W'(1);
      if (w_confirm) begin
        detect_q <= cycle_cnt_q;
        evt_q    <= evt_sat_inc(evt_q);
      end
    end
  end

  assign deadlock        = deadlock_q;
  assign deadlock_pulse  = pulse_q;
  assign detect_cycle    = detect_q;
  assign event_count     = evt_q;
  assign state_o         = state_q;
  assign snap_idle       = w_snap[VEC_W-1 -: NUM_PROC];
  assign snap_chan_block = w_snap[NUM_AXIS +: NUM_PROC];
  assign snap_axis       = w_snap[NUM_AXIS-1:0];

`ifdef DEADLOCK_CONFIRM_REPORT_EN
  // Simulation-only report; on a confirm edge the snapshot equals w_cur.
  always @(posedge clock) begin
    if (!reset && w_confirm) begin
      $write("deadlock_confirm: deadlock at cycle %0h idle=%h chan=%h axis=%h non-idle procs:",
             cycle_cnt_q, proc_idle_vec, proc_chan_block_vec, axis_block_sigs);
      for (int i = 0; i < NUM_PROC; i++) begin
        if (!proc_idle_vec[i]) $write(" %0d", i);
      end
      $write("\n");
    end
    if (!reset && state_q == CONFIRMED && clear) begin
      $display("deadlock_confirm: deadlock cleared at cycle %0h", cycle_cnt_q);
    end
  end
`else
  // Reporting disabled: no additional logic.
`endif

endmodule
`default_nettype wire

// File: tb/tb_deadlock_confirm.sv
`default_nettype none
// ============================================================================
// Module      : tb_deadlock_confirm
// Description : Self-checking bench for deadlock_confirm. Two instances
//               (CONFIRM_CYCLES=4 and =1) share stimulus; each is checked
//               every cycle against a run-length model, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deadlock_confirm;

  logic        clock = 1'b0;
  logic        reset;
  logic        block_in;
  logic        clear;
  logic [12:0] idle_v;
  logic [12:0] chan_v;
  logic [2:0]  axis_v;

  logic        d4_deadlock, d4_pulse;
  logic [12:0] d4_sidle, d4_schan;
  logic [2:0]  d4_saxis;
  logic [31:0] d4_detect;
  logic [7:0]  d4_evt;
  logic [1:0]  d4_state;

  logic        d1_deadlock, d1_pulse;
  logic [12:0] d1_sidle, d1_schan;
  logic [2:0]  d1_saxis;
  logic [7:0]  d1_detect;
  logic [7:0]  d1_evt;
  logic [1:0]  d1_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  deadlock_confirm #(.NUM_PROC(13), .NUM_AXIS(3), .CONFIRM_CYCLES(4), .CNT_W(16), .CYC_W(32)) dut4 (
    .clock(clock), .reset(reset), .block_in(block_in),
    .proc_idle_vec(idle_v), .proc_chan_block_vec(chan_v), .axis_block_sigs(axis_v),
    .clear(clear), .deadlock(d4_deadlock), .deadlock_pulse(d4_pulse),
    .snap_idle(d4_sidle), .snap_chan_block(d4_schan), .snap_axis(d4_saxis),
    .detect_cycle(d4_detect), .event_count(d4_evt), .state_o(d4_state));

  deadlock_confirm #(.NUM_PROC(13), .NUM_AXIS(3), .CONFIRM_CYCLES(1), .CNT_W(4), .CYC_W(8)) dut1 (
    .clock(clock), .reset(reset), .block_in(block_in),
    .proc_idle_vec(idle_v), .proc_chan_block_vec(chan_v), .axis_block_sigs(axis_v),
    .clear(clear), .deadlock(d1_deadlock), .deadlock_pulse(d1_pulse),
    .snap_idle(d1_sidle), .snap_chan_block(d1_schan), .snap_axis(d1_saxis),
    .detect_cycle(d1_detect), .event_count(d1_evt), .state_o(d1_state));

  // Model: length of the current run of identical blocked samples.
  typedef struct packed {
    logic        conf;
    logic [31:0] run;
    logic [12:0] si;
    logic [12:0] sc;
    logic [2:0]  sa;
    logic [31:0] cyc;
    logic [31:0] det;
    logic [7:0]  evt;
    logic        pulse;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mstep(mdl_t m, logic rst, logic blk, logic clr,
                                 logic [12:0] pi, logic [12:0] pc, logic [2:0] ax,
                                 int n, logic [31:0] cmax);
    mdl_t r;
    r = m;
    if (rst) begin
      r = '0;
      return r;
    end
    r.pulse = 1'b0;
    if (m.conf) begin
      if (clr) begin
        r.conf = 1'b0;
        r.run  = 0;
      end
    end else if (clr || !blk) begin
      r.run = 0;
    end else begin
      if (m.run > 0 && {pi, pc, ax} == {m.si, m.sc, m.sa}) begin
        r.run = m.run + 1;
      end else begin
        r.si  = pi;
        r.sc  = pc;
        r.sa  = ax;
        r.run = 1;
      end
      if (r.run == 32'(n)) begin
        r.conf  = 1'b1;
        r.pulse = 1'b1;
        r.det   = m.cyc;
        r.run   = 0;
        if (m.evt != 8'hFF) r.evt = m.evt + 8'd1;
      end
    end
    r.cyc = (m.cyc == cmax) ? m.cyc : m.cyc + 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] mstate(mdl_t m);
    if (m.conf) return 32'd2;
    if (m.run > 0) return 32'd1;
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("d4.deadlock", 32'(d4_deadlock), 32'(m4.conf));
      chk("d4.pulse",    32'(d4_pulse),    32'(m4.pulse));
      chk("d4.snap_idle", 32'(d4_sidle),   32'(m4.si));
      chk("d4.snap_chan", 32'(d4_schan),   32'(m4.sc));
      chk("d4.snap_axis", 32'(d4_saxis),   32'(m4.sa));
      chk("d4.detect",   d4_detect,        m4.det);
      chk("d4.evt",      32'(d4_evt),      32'(m4.evt));
      chk("d4.state",    32'(d4_state),    mstate(m4));
      chk("d1.deadlock", 32'(d1_deadlock), 32'(m1.conf));
      chk("d1.pulse",    32'(d1_pulse),    32'(m1.pulse));
      chk("d1.snap_idle", 32'(d1_sidle),   32'(m1.si));
      chk("d1.snap_chan", 32'(d1_schan),   32'(m1.sc));
      chk("d1.snap_axis", 32'(d1_saxis),   32'(m1.sa));
      chk("d1.detect",   32'(d1_detect),   m1.det);
      chk("d1.evt",      32'(d1_evt),      32'(m1.evt));
      chk("d1.state",    32'(d1_state),    mstate(m1));
    end
  end

  // One clock edge: the models consume the inputs held across the edge.
  task automatic tick();
    @(posedge clock);
    m4 = mstep(m4, reset, block_in, clear, idle_v, chan_v, axis_v, 4, 32'hFFFF_FFFF);
    m1 = mstep(m1, reset, block_in, clear, idle_v, chan_v, axis_v, 1, 32'h0000_00FF);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    block_in = 1'b0;
    clear    = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    m4 = '0;
    m1 = '0;
    reset = 1'b1; block_in = 1'b0; clear = 1'b0;
    idle_v = 13'h1FFE; chan_v = 13'h0001; axis_v = 3'b010;
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset.deadlock", 32'(d4_deadlock), 32'd0);
    chk("reset.state",    32'(d4_state),    32'd0);
    chk("reset.snap",     32'(d4_sidle),    32'd0);

    // A: constant picture, blocked from edge 10.
    do_reset();
    for (int e = 0; e <= 15; e++) begin
      block_in = (e >= 10);
      clear    = (e == 15);
      tick();
      if (e == 9)  chk("A.idle",  32'(d4_state), 32'd0);
      if (e == 10) chk("A.armed", 32'(d4_state), 32'd1);
      if (e == 12) chk("A.early", 32'(d4_deadlock), 32'd0);
      if (e == 13) begin
        chk("A.deadlock", 32'(d4_deadlock), 32'd1);
        chk("A.pulse",    32'(d4_pulse),    32'd1);
        chk("A.detect",   d4_detect,        32'd13);
        chk("A.evt",      32'(d4_evt),      32'd1);
        chk("A.snap",     32'(d4_sidle),    32'h1FFE);
      end
      if (e == 14) begin
        chk("A.pulse_low", 32'(d4_pulse),    32'd0);
        chk("A.sticky",    32'(d4_deadlock), 32'd1);
      end
      if (e == 15) begin
        chk("A.cleared",  32'(d4_deadlock), 32'd0);
        chk("A.clr_idle", 32'(d4_state),    32'd0);
      end
    end

    // B: block drops at edge 13, returns at 14.
    do_reset();
    for (int e = 0; e <= 18; e++) begin
      block_in = (e >= 10 && e != 13);
      clear    = 1'b0;
      tick();
      if (e == 13) chk("B.dropped", 32'(d4_deadlock), 32'd0);
      if (e == 16) chk("B.early",   32'(d4_deadlock), 32'd0);
      if (e == 17) begin
        chk("B.deadlock", 32'(d4_deadlock), 32'd1);
        chk("B.detect",   d4_detect,        32'd17);
      end
    end

    // C: picture changes at edge 12 and restarts the count.
    do_reset();
    for (int e = 0; e <= 16; e++) begin
      block_in = (e >= 10);
      idle_v   = (e >= 12) ? 13'h1FFF : 13'h1FFE;
      tick();
      if (e == 14) chk("C.early", 32'(d4_deadlock), 32'd0);
      if (e == 15) begin
        chk("C.deadlock", 32'(d4_deadlock), 32'd1);
        chk("C.snap",     32'(d4_sidle),    32'h1FFF);
        chk("C.detect",   d4_detect,        32'd15);
      end
    end
    idle_v = 13'h0F0E;

    // D: CONFIRM_CYCLES=1 instance, clear and block together at edge 8.
    do_reset();
    for (int e = 0; e <= 11; e++) begin
      block_in = (e == 5 || e == 8 || e == 9);
      clear    = (e == 8);
      tick();
      if (e == 5) begin
        chk("D.deadlock", 32'(d1_deadlock), 32'd1);
        chk("D.detect",   32'(d1_detect),   32'd5);
        chk("D.snap",     32'(d1_sidle),    32'h0F0E);
      end
      if (e == 6) chk("D.pulse_low", 32'(d1_pulse), 32'd0);
      if (e == 8) begin
        chk("D.cleared", 32'(d1_deadlock), 32'd0);
        chk("D.idle",    32'(d1_state),    32'd0);
      end
      if (e == 9) begin
        chk("D.reconfirm", 32'(d1_deadlock), 32'd1);
        chk("D.evt",       32'(d1_evt),      32'd2);
        chk("D.detect2",   32'(d1_detect),   32'd9);
      end
    end

    // E: reset during ARMED at edge 12, block held high.
    for (int e = 0; e <= 17; e++) begin
      block_in = (e >= 10);
      clear    = 1'b0;
      reset    = (e == 12);
      tick();
      if (e == 12) begin
        chk("E.d4_state", 32'(d4_state),    32'd0);
        chk("E.d1_dl",    32'(d1_deadlock), 32'd0);
        chk("E.d1_evt",   32'(d1_evt),      32'd0);
        chk("E.d1_snap",  32'(d1_sidle),    32'd0);
      end
      if (e == 13) chk("E.d1_detect", 32'(d1_detect), 32'd0);
      if (e == 15) chk("E.d4_early",  32'(d4_deadlock), 32'd0);
      if (e == 16) begin
        chk("E.d4_deadlock", 32'(d4_deadlock), 32'd1);
        chk("E.d4_detect",   d4_detect,        32'd3);
      end
    end
    reset = 1'b0;

    // F: 300 confirm/clear rounds on the single-cycle instance.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      block_in = 1'b1; clear = 1'b0;
      tick();
      block_in = 1'b0; clear = 1'b1;
      tick();
    end
    chk("F.evt_sat",    32'(d1_evt),    32'd255);
    chk("F.cyc_sat",    32'(d1_detect), 32'd255);
    chk("F.d4_never",   32'(d4_evt),    32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
